// File: rtl/dcache_pkg.sv
// ============================================================================
// Module      : dcache_pkg
// Description : Shared constants and types for the data-cache write buffer:
//               line geometry, memory-side FSM encoding and the buffered
//               line entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcache_pkg;

  localparam int LINE_W   = 256;  // cache line width in bits
  localparam int LADDR_W  = 27;   // line address, byte address bits [31:5]
  localparam int OFFSET_W = 5;    // byte offset inside a 32-byte line

  // Memory-side sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2
  } mem_state_e;

  // One buffered dirty line
  typedef struct packed {
    logic [LADDR_W-1:0] laddr;
    logic [LINE_W-1:0]  data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/dcache_write_buffer_fifo.sv
// ============================================================================
// Module      : wb_fifo
// Description : Line-entry FIFO for the write buffer. Holds DEPTH entries,
//               keeps head/tail pointers and an occupancy count, and performs
//               a parallel youngest-match lookup of one line address.
//               A write that matches a buffered line (other than the head
//               while it is in flight to memory) overwrites that entry;
//               otherwise it is appended at the tail.
// Ports       : clk_i, rst_n_i        clock, async active-low reset
//               wr_en_i               write accepted this cycle (never when full)
//               laddr_i, wr_data_i    lookup / write line address and data
//               pop_i                 retire the head entry
//               inflight_head_i       head is owned by the memory sequencer
//               count_o, full_o       occupancy
//               head_o                oldest entry
//               rd_hit_o, rd_data_o   youngest match among all valid entries
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo
  import dcache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     wr_en_i,
  input  logic [LADDR_W-1:0]       laddr_i,
  input  logic [LINE_W-1:0]        wr_data_i,
  input  logic                     pop_i,
  input  logic                     inflight_head_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output wb_entry_t                head_o,
  output logic                     rd_hit_o,
  output logic [LINE_W-1:0]        rd_data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          mem_q [DEPTH];
  wb_entry_t          mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               wr_hit;
  logic [PTR_W-1:0]   wr_slot;
  logic [PTR_W-1:0]   rd_slot;
  logic [PTR_W-1:0]   slot;
  logic               push_new;

  // Walk entries from oldest to youngest so the last match seen is the
  // youngest. The read lookup sees every valid entry; the coalescing lookup
  // skips age 0 while the head is being written to memory, because its data
  // has already been captured for the memory transaction.
  always_comb begin
    rd_hit_o = 1'b0;
    rd_slot  = '0;
    wr_hit   = 1'b0;
    wr_slot  = '0;
    slot     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (mem_q[slot].laddr == laddr_i)) begin
        rd_hit_o = 1'b1;
        rd_slot  = slot;
        if (!((i == 0) && inflight_head_i)) begin
          wr_hit  = 1'b1;
          wr_slot = slot;
        end
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    head_d   = head_q;
    tail_d   = tail_q;
    push_new = 1'b0;
    if (wr_en_i) begin
      if (wr_hit) begin
        mem_d[wr_slot].data = wr_data_i;
      end else begin
        push_new            = 1'b1;
        mem_d[tail_q].laddr = laddr_i;
        mem_d[tail_q].data  = wr_data_i;
        tail_d              = tail_q + PTR_W'(1);
      end
    end
    if (pop_i) begin
      head_d = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_new) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Line storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign count_o   = count_q;
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign head_o    = mem_q[head_q];
  assign rd_data_o = mem_q[rd_slot].data;

endmodule

`default_nettype wire

// File: rtl/dcache_write_buffer.sv
// ============================================================================
// Module      : dcache_write_buffer
// Description : Write buffer between the data cache and line memory.
//               Dirty-line write-backs are absorbed into a FIFO and acked one
//               cycle after sampling; entries drain to memory in the
//               background. Line reads are served from the buffer on a hit,
//               otherwise forwarded to memory ahead of further draining.
// Ports       : clk_i, rst_n_i              clock, async active-low reset
//               c_addr_i/c_data_i/c_enable_i/c_write_i   cache request
//               c_ack_o, c_data_o           cache completion and read line
//               m_addr_o/m_data_o/m_enable_o/m_write_o   memory request
//               m_ack_i, m_data_i           memory completion and read line
//               empty_o, count_o            buffer status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_write_buffer #(
  parameter int DEPTH   = 4,
  parameter int LINE_W  = 256,
  parameter int LADDR_W = 27
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [31:0]              c_addr_i,
  input  logic [LINE_W-1:0]        c_data_i,
  input  logic                     c_enable_i,
  input  logic                     c_write_i,
  output logic                     c_ack_o,
  output logic [LINE_W-1:0]        c_data_o,
  output logic [31:0]              m_addr_o,
  output logic [LINE_W-1:0]        m_data_o,
  output logic                     m_enable_o,
  output logic                     m_write_o,
  input  logic                     m_ack_i,
  input  logic [LINE_W-1:0]        m_data_i,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  import dcache_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  mem_state_e          state_q, state_d;
  logic                c_ack_q, c_ack_d;
  logic [LINE_W-1:0]   c_data_q, c_data_d;
  logic                rd_pend_q, rd_pend_d;
  logic [LADDR_W-1:0]  rd_laddr_q, rd_laddr_d;
  logic [31:0]         m_addr_q, m_addr_d;
  logic [LINE_W-1:0]   m_data_q, m_data_d;

  logic [LADDR_W-1:0]  req_laddr;
  logic                unused_addr_bits;
  logic                accept;
  logic                wr_en;
  logic                pop;
  logic                inflight_head;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  wb_entry_t           head;
  logic                rd_hit;
  logic [LINE_W-1:0]   rd_data;

  assign req_laddr        = c_addr_i[31:OFFSET_W];
  assign unused_addr_bits = ^c_addr_i[OFFSET_W-1:0];

  // A held request is only sampled once: not in its ack cycle, and not while
  // a read miss is waiting on memory (that read is still being presented).
  assign accept = c_enable_i && !c_ack_q && !rd_pend_q;
  assign wr_en  = accept && c_write_i && !fifo_full;
  assign pop    = (state_q == DRAIN) && m_ack_i;

  // The head is also treated as in flight in the IDLE cycle that launches
  // its drain: the memory data register captures the head on that edge, so
  // a coalesce into it on the same edge would be lost.
  assign inflight_head = (state_q == DRAIN) ||
                         ((state_q == IDLE) && !rd_pend_q && (fifo_count != '0));

  wb_fifo #(
    .DEPTH           (DEPTH)
  ) u_fifo (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .wr_en_i         (wr_en),
    .laddr_i         (req_laddr),
    .wr_data_i       (c_data_i),
    .pop_i           (pop),
    .inflight_head_i (inflight_head),
    .count_o         (fifo_count),
    .full_o          (fifo_full),
    .head_o          (head),
    .rd_hit_o        (rd_hit),
    .rd_data_o       (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    c_ack_d    = 1'b0;
    c_data_d   = c_data_q;
    rd_pend_d  = rd_pend_q;
    rd_laddr_d = rd_laddr_q;
    m_addr_d   = m_addr_q;
    m_data_d   = m_data_q;

    // Cache side
    if (wr_en) begin
      c_ack_d = 1'b1;
    end
    if (accept && !c_write_i) begin
      if (rd_hit) begin
        c_ack_d  = 1'b1;
        c_data_d = rd_data;
      end else begin
        rd_pend_d  = 1'b1;
        rd_laddr_d = req_laddr;
      end
    end

    // Memory side; every transaction returns through IDLE, which guarantees
    // a gap cycle with m_enable_o low between transactions.
    unique case (state_q)
      IDLE: begin
        if (rd_pend_q) begin
          state_d  = READ;
          m_addr_d = {rd_laddr_q, {OFFSET_W{1'b0}}};
        end else if (fifo_count != '0) begin
          state_d  = DRAIN;
          m_addr_d = {head.laddr, {OFFSET_W{1'b0}}};
          m_data_d = head.data;
        end
      end
      DRAIN: begin
        if (m_ack_i) begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (m_ack_i) begin
          state_d   = IDLE;
          c_ack_d   = 1'b1;
          c_data_d  = m_data_i;
          rd_pend_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      c_ack_q    <= 1'b0;
      c_data_q   <= '0;
      rd_pend_q  <= 1'b0;
      rd_laddr_q <= '0;
      m_addr_q   <= '0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      c_ack_q    <= c_ack_d;
      c_data_q   <= c_data_d;
      rd_pend_q  <= rd_pend_d;
      rd_laddr_q <= rd_laddr_d;
      m_addr_q   <= m_addr_d;
      m_data_q   <= m_data_d;
    end
  end

  assign c_ack_o    = c_ack_q;
  assign c_data_o   = c_data_q;
  assign m_addr_o   = m_addr_q;
  assign m_data_o   = m_data_q;
  assign m_enable_o = (state_q != IDLE);
  assign m_write_o  = (state_q == DRAIN);
  assign empty_o    = (state_q == IDLE) && (fifo_count == '0);
  assign count_o    = fifo_count;

endmodule

`default_nettype wire

// File: tb/tb_dcache_write_buffer.sv
// ============================================================================
// Module      : tb_dcache_write_buffer
// Description : Self-checking bench for dcache_write_buffer. A driver issues
//               cache requests and queues the expected completion; a monitor
//               pops and checks on every c_ack_o. A line-memory model with a
//               fixed latency logs write/read order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_write_buffer;

  localparam int LAT = 10;

  logic         clk;
  logic         rst_n;
  logic [31:0]  c_addr;
  logic [255:0] c_data;
  logic         c_enable;
  logic         c_write;
  logic         c_ack;
  logic [255:0] c_rdata;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata;
  logic         m_enable;
  logic         m_write;
  logic         m_ack;
  logic [255:0] m_rdata;
  logic         empty;
  logic [2:0]   count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit           is_read;
    logic [255:0] data;
    int           cyc;
    int           lat;
  } exp_t;

  exp_t         sb [$];
  logic [255:0] mem_model [int];
  int           wr_log [$];
  int           wr_ack_cyc [$];
  int           rd_log [$];
  int           ev_log [$];   // write lines as +line, read lines as -(line+1)

  dcache_write_buffer #(
    .DEPTH      (4),
    .LINE_W     (256),
    .LADDR_W    (27)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .c_addr_i   (c_addr),
    .c_data_i   (c_data),
    .c_enable_i (c_enable),
    .c_write_i  (c_write),
    .c_ack_o    (c_ack),
    .c_data_o   (c_rdata),
    .m_addr_o   (m_addr),
    .m_data_o   (m_wdata),
    .m_enable_o (m_enable),
    .m_write_o  (m_write),
    .m_ack_i    (m_ack),
    .m_data_i   (m_rdata),
    .empty_o    (empty),
    .count_o    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every ack must correspond to the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && c_ack) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack actual=1 required=0");
        end else begin
          e = sb.pop_front();
          if (e.is_read) chk("read_data", c_rdata, e.data);
          if (e.lat >= 0) chk("ack_latency", 256'(cyc - e.cyc), 256'(e.lat));
        end
      end
    end
  end

  // Line memory: acks LAT cycles after a request is first seen.
  initial begin
    int           cnt;
    int           line;
    logic [31:0]  cap_addr;
    logic         cap_write;
    logic [255:0] cap_data;
    m_ack   = 1'b0;
    m_rdata = '0;
    cnt     = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt   = 0;
        m_ack = 1'b0;
      end else if (m_ack) begin
        m_ack = 1'b0;
        cnt   = 0;
      end else if (m_enable) begin
        cnt++;
        if (cnt == 1) begin
          cap_addr  = m_addr;
          cap_write = m_write;
          cap_data  = m_wdata;
        end
        if (cnt == LAT) begin
          chk("mem_addr_stable", 256'(m_addr), 256'(cap_addr));
          chk("mem_write_stable", 256'(m_write), 256'(cap_write));
          line = int'(m_addr[31:5]);
          if (m_write) begin
            chk("mem_data_stable", m_wdata, cap_data);
            mem_model[line] = m_wdata;
            wr_log.push_back(line);
            wr_ack_cyc.push_back(cyc);
            ev_log.push_back(line);
          end else begin
            m_rdata = mem_model.exists(line) ? mem_model[line] : '0;
            rd_log.push_back(line);
            ev_log.push_back(-(line + 1));
          end
          m_ack = 1'b1;
          cnt   = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Present one request, queue its expected completion, hold until acked.
  task automatic req(input bit w, input logic [31:0] a, input logic [255:0] d,
                     input int lat, output int ack_cyc);
    exp_t e;
    int   n;
    @(negedge clk);
    c_enable = 1'b1;
    c_write  = w;
    c_addr   = a;
    c_data   = w ? d : '0;
    e.is_read = !w;
    e.data    = d;
    e.cyc     = cyc;
    e.lat     = lat;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!c_ack && n < 200);
    ack_cyc = cyc;
    if (!c_ack) begin
      checks++;
      failures++;
      $display("FAIL req_timeout addr=%0h actual=no_ack required=ack", a);
      sb.delete(sb.size() - 1);
    end
    c_enable = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!empty && n < 300);
    chk(name, 256'(empty), 256'(1));
  endtask

  task automatic wait_drain_start(input string name);
    int n;
    n = 0;
    while (!(m_enable && m_write) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, 256'(m_enable && m_write), 256'(1));
  endtask

  initial begin
    logic [255:0] fdat [5];
    logic [255:0] d;
    int           ack_cyc;
    int           base;
    int           rbase;

    rst_n    = 1'b0;
    c_enable = 1'b0;
    c_write  = 1'b0;
    c_addr   = '0;
    c_data   = '0;
    mem_model[2] = {16{16'hECFA}};

    repeat (3) @(negedge clk);
    chk("rst_c_ack", 256'(c_ack), 256'(0));
    chk("rst_m_enable", 256'(m_enable), 256'(0));
    chk("rst_m_write", 256'(m_write), 256'(0));
    chk("rst_m_addr", 256'(m_addr), 256'(0));
    chk("rst_m_data", m_wdata, 256'(0));
    chk("rst_c_data", c_rdata, 256'(0));
    chk("rst_count", 256'(count), 256'(0));
    chk("rst_empty", 256'(empty), 256'(1));
    #2 rst_n = 1'b1;

    // Single write-back of line 32
    d = {8{32'h1111_0001}};
    req(1'b1, 32'h0000_0400, d, 1, ack_cyc);
    chk("t1_count_after_ack", 256'(count), 256'(1));
    @(negedge clk);
    chk("t1_m_enable", 256'(m_enable), 256'(1));
    chk("t1_m_write", 256'(m_write), 256'(1));
    chk("t1_m_addr", 256'(m_addr), 256'(32'h0000_0400));
    chk("t1_m_data", m_wdata, d);
    wait_empty("t1_empty");
    chk("t1_mem_line32", mem_model[32], d);
    chk("t1_count_end", 256'(count), 256'(0));

    // Five back-to-back writes into a 4-deep buffer
    base = wr_log.size();
    for (int i = 0; i < 5; i++) fdat[i] = {8{32'(32'hF0F0_0000 | i)}};
    for (int i = 0; i < 4; i++) req(1'b1, 32'(i * 32'h200), fdat[i], 1, ack_cyc);
    chk("t2_count_full", 256'(count), 256'(4));
    req(1'b1, 32'h0000_0800, fdat[4], -1, ack_cyc);
    if (wr_ack_cyc.size() > base)
      chk("t2_fifth_ack_after_pop", 256'(ack_cyc - wr_ack_cyc[base]), 256'(2));
    else
      chk("t2_first_drain_seen", 256'(wr_ack_cyc.size()), 256'(base + 1));
    wait_empty("t2_empty");
    chk("t2_drain_count", 256'(wr_log.size() - base), 256'(5));
    for (int i = 0; i < 5; i++) begin
      if (wr_log.size() > base + i) chk("t2_drain_order", 256'(wr_log[base + i]), 256'(i * 16));
      chk("t2_mem_data", mem_model[i * 16], fdat[i]);
    end

    // Read hit on a buffered line (0x210 lies in line 16)
    rbase = rd_log.size();
    req(1'b1, 32'h0000_0200, {32{8'hAA}}, 1, ack_cyc);
    req(1'b0, 32'h0000_0210, {32{8'hAA}}, 1, ack_cyc);
    wait_empty("t3_empty");
    chk("t3_no_mem_read", 256'(rd_log.size() - rbase), 256'(0));

    // Coalescing never targets the in-flight head
    base = wr_log.size();
    req(1'b1, 32'h0000_0400, {8{32'hAAAA_0004}}, 1, ack_cyc);
    wait_drain_start("t4_drain_start");
    chk("t4_count_a", 256'(count), 256'(1));
    req(1'b1, 32'h0000_0400, {8{32'hBBBB_0004}}, 1, ack_cyc);
    chk("t4_count_b", 256'(count), 256'(2));
    req(1'b1, 32'h0000_0400, {8{32'hCCCC_0004}}, 1, ack_cyc);
    chk("t4_count_c", 256'(count), 256'(2));
    req(1'b0, 32'h0000_0400, {8{32'hCCCC_0004}}, 1, ack_cyc);
    wait_empty("t4_empty");
    chk("t4_mem_line32", mem_model[32], {8{32'hCCCC_0004}});
    chk("t4_write_count", 256'(wr_log.size() - base), 256'(2));

    // Read miss waits only for the drain already in flight
    base = ev_log.size();
    req(1'b1, 32'h0000_1000, {8{32'h6060_0080}}, 1, ack_cyc);
    req(1'b1, 32'h0000_1020, {8{32'h6161_0081}}, 1, ack_cyc);
    req(1'b0, 32'h0000_0040, {16{16'hECFA}}, -1, ack_cyc);
    wait_empty("t5_empty");
    chk("t5_event_count", 256'(ev_log.size() - base), 256'(3));
    if (ev_log.size() >= base + 3) begin
      chk("t5_ev0_drain128", 256'(ev_log[base]), 256'(128));
      chk("t5_ev1_read2", 256'(ev_log[base + 1]), 256'(-3));
      chk("t5_ev2_drain129", 256'(ev_log[base + 2]), 256'(129));
    end

    // Asynchronous reset in the middle of a drain
    req(1'b1, 32'h0000_0600, {8{32'h4848_0030}}, 1, ack_cyc);
    req(1'b1, 32'h0000_0800, {8{32'h4040_0040}}, 1, ack_cyc);
    wait_drain_start("t6_drain_start");
    chk("t6_drain_addr", 256'(m_addr), 256'(32'h0000_0600));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_m_enable", 256'(m_enable), 256'(0));
    chk("t6_m_write", 256'(m_write), 256'(0));
    chk("t6_count", 256'(count), 256'(0));
    chk("t6_empty", 256'(empty), 256'(1));
    chk("t6_m_addr", 256'(m_addr), 256'(0));
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    base = wr_log.size();
    req(1'b1, 32'h0000_0A00, {8{32'h5050_0050}}, 1, ack_cyc);
    // Line 48 was discarded by reset, so memory still holds the earlier data
    req(1'b0, 32'h0000_0600, fdat[3], -1, ack_cyc);
    wait_empty("t6_empty_end");
    chk("t6_mem_line80", mem_model[80], {8{32'h5050_0050}});
    chk("t6_writes_after_reset", 256'(wr_log.size() - base), 256'(1));

    repeat (3) @(negedge clk);
    chk("sb_drained", 256'(sb.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_write_buffer.md
Name: dcache_write_buffer

Overview:
- Sits between the data cache memory port and Data_Memory, on the 256-bit line interface.
- Absorbs dirty-line write-backs into a small FIFO and acks them quickly, so the cache no longer stalls for full memory write latency.
- Drains entries to memory in the background.
- Serves cache line reads from buffered data when the address matches; otherwise forwards the read to memory.

Parameters:
- DEPTH, 4, number of line entries; power of two, 2..8.
- LINE_W, 256, line width in bits.
- LADDR_W, 27, line-address width (addr[31:5]).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous, active-low reset
- c_addr_i  in  32  cache request byte address; bits [4:0] ignored
- c_data_i  in  LINE_W  cache write line
- c_enable_i  in  1  cache request valid
- c_write_i  in  1  1=write-back, 0=line read
- c_ack_o  out  1  one-cycle completion pulse to cache
- c_data_o  out  LINE_W  read line; valid while c_ack_o=1
- m_addr_o  out  32  memory byte address, {line,5'b0}
- m_data_o  out  LINE_W  memory write line
- m_enable_o  out  1  memory request valid
- m_write_o  out  1  memory write
- m_ack_i  in  1  memory completion pulse
- m_data_i  in  LINE_W  memory read line; valid with m_ack_i
- empty_o  out  1  no entries buffered and memory FSM IDLE
- count_o  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (async, rst_n_i=0), effective immediately:
  - c_ack_o=0, m_enable_o=0, m_write_o=0.
  - m_addr_o=0, m_data_o=0, c_data_o=0.
  - count_o=0, empty_o=1, FSM=IDLE.
  - Buffered data is discarded; a reset mid-drain abandons the memory transaction.
- Cache-side handshake:
  - A request is sampled only on cycles where c_enable_i=1 and c_ack_o=0.
  - The cache holds the request stable until it sees c_ack_o.
  - The cache may present its next request in the cycle after the ack.
  - At most one cache request is outstanding.
- Write, buffer not full (count<DEPTH at sample edge):
  - If the line address matches a non-in-flight entry, overwrite that entry's data (coalesce; count unchanged).
  - Otherwise push at tail.
  - c_ack_o=1 in the next cycle, giving a 1-cycle write latency.
- Write, buffer full: not accepted; re-evaluated each cycle until a drain pop frees a slot.
  - A slot freed by a pop at edge T accepts the write at edge T+1.
- The head entry being drained (DRAIN state) is never coalesced into; a same-line write allocates a new entry.
- Read lookup:
  - Compare against all valid entries; the youngest match wins.
  - Hit: c_data_o=entry data, c_ack_o=1 next cycle. No memory access is made.
  - Miss: mark the read pending; it is served via the memory FSM.
- Memory FSM states: IDLE, DRAIN, READ.
  - IDLE→READ if a read is pending (reads take priority over draining).
  - IDLE→DRAIN if count>0 and no read is pending.
  - DRAIN:
    - m_enable_o=1, m_write_o=1, m_addr_o/m_data_o from head, held stable.
    - On m_ack_i: pop head, →IDLE.
  - READ:
    - m_enable_o=1, m_write_o=0, m_addr_o=pending line.
    - On m_ack_i: latch m_data_i into c_data_o, c_ack_o=1 next cycle, →IDLE.
  - An in-flight DRAIN is never aborted; a read arriving during DRAIN waits for its completion.
  - At least one IDLE cycle occurs between memory transactions (m_enable_o deasserts for ≥1 cycle).
- Simultaneous push and pop on the same edge: count unchanged; pointers wrap modulo DEPTH.
- c_data_o holds its last value when c_ack_o=0.
- Memory ordering is preserved:
  - Drains leave in FIFO order.
  - A read that misses the buffer cannot depend on any buffered line.

Decomposition:
- Shared package dcache_pkg:
  - LINE_W, LADDR_W, OFFSET_W=5.
  - Memory-FSM enum {IDLE, DRAIN, READ}.
  - Entry struct {laddr, data}.
- Sub-module wb_fifo: storage, head/tail pointers, count, and parallel youngest-match CAM lookup with in-flight-head exclusion. The top level holds the handshake logic and the memory FSM.

Test Plan:
- Single write-back: write line 0x0000_0400 with data D (memory model, 10-cycle latency).
  - c_ack_o one cycle after sample.
  - m_enable_o/m_write_o rise in the following cycles.
  - Memory line 32 equals D after m_ack_i.
  - empty_o=1 afterwards.
- Fill beyond DEPTH: 5 back-to-back writes to lines 0x0000, 0x0200, 0x0400, 0x0600, 0x0800 with DEPTH=4.
  - The first four are acked at 1-cycle latency.
  - The fifth is acked only after the first drain's m_ack_i.
  - Memory receives lines in issue order.
- Read hit on buffer: write 0x0200 with 0xAA..AA, then immediately read 0x0210.
  - c_data_o=0xAA..AA with c_ack_o one cycle after the read is sampled.
  - No m_enable_o with m_write_o=0 observed.
- Coalesce vs in-flight: write 0x0400=A, wait until DRAIN starts, write 0x0400=B, then write 0x0400=C.
  - count_o goes 1→2→2.
  - Memory line 32 ends as C.
  - A read of 0x0400 returns C.
- Read miss behind drain: 2 buffered writes, then a read of 0x0040 (memory holds 0xECFA…).
  - The read waits for the current drain's ack only.
  - The read is issued before the second drain.
  - c_data_o=0xECFA…ECFA.
- Async reset mid-DRAIN: assert rst_n_i between clock edges.
  - m_enable_o=0, count_o=0, empty_o=1 with no clock edge required.
  - After release, normal operation resumes.
